isram_arb: RTL and testbench

- Two-port arbiter and sequencer in front of the dual-half instruction SRAM (AW-bit word address, 64-bit word, two 32-bit halves with separate chip selects csn0/csn1 and per-byte write enables).
- Port I is the instruction fetch unit: 64-bit read-only.
- Port D is the load/store unit: 32-bit reads and byte-masked writes to ITCM space.
- Generates SRAM chip selects, half selection, write-data replication and response steering, with valid/ready handshakes and a per-port response holding register.

---
 rtl/isram_arb.sv | 183 ++++++++++++++++++
 tb/tb_isram_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isram_arb.sv
// isram_arb: two-port arbiter and sequencer in front of the dual-half
// instruction SRAM (64-bit words split into two 32-bit halves).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req_* / i_rsp_*       fetch port: 64-bit reads, valid/ready handshakes
//   d_req_* / d_rsp_*       LSU port: 32-bit reads and byte-masked writes
//   ram_csn0 / ram_csn1     low / high half chip selects (active low)
//   ram_wen                 write enable (active low)
//   ram_ben                 per-byte write enables (active high)
//   ram_addr, ram_din       word address and replicated write data
//   ram_dout                read data, valid the cycle after a selected read
//
// Build option: define ISRAM_ARB_DPRIO_EN to give D fixed priority over I,
// with a 4-bit anti-starvation counter that hands I the grant after it has
// waited 15 cycles. Without it, arbitration is round-robin.
module isram_arb #(
    parameter int AW = 16,
    parameter int DW = 64,
    parameter int BW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [AW+2:0]   i_req_addr,
    output logic            i_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [63:0]     i_rsp_rdata,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW+2:0]   d_req_addr,
    input  logic            d_req_wr,
    input  logic [3:0]      d_req_wmask,
    input  logic [31:0]     d_req_wdata,
    output logic            d_rsp_valid,
    input  logic            d_rsp_ready,
    output logic [31:0]     d_rsp_rdata,
    output logic            ram_csn0,
    output logic            ram_csn1,
    output logic            ram_wen,
    output logic [BW-1:0]   ram_ben,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    logic        i_infl_q, d_infl_q;
    logic        d_half_q, d_wr_q;
    logic        i_hold_vld_q, d_hold_vld_q;
    logic [63:0] i_hold_q;
    logic [31:0] d_hold_q;

    logic        i_elig, d_elig;
    logic        i_cand, d_cand;
    logic        gnt_i, gnt_d;
    logic [31:0] d_steer;

    // Low address bits select bytes within a word / half and are not needed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_req_addr[2:0], d_req_addr[1:0]};

    // A port may issue only if its response path can absorb one more beat:
    // nothing held, and no inflight beat that is about to be parked in hold.
    assign i_elig = ~i_hold_vld_q & ~(i_infl_q & ~i_rsp_ready);
    assign d_elig = ~d_hold_vld_q & ~(d_infl_q & ~d_rsp_ready);
    // rst_n gates the candidates so nothing is granted while reset is held.
    assign i_cand = i_req_valid & i_elig & rst_n;
    assign d_cand = d_req_valid & d_elig & rst_n;

`ifdef ISRAM_ARB_DPRIO_EN
    logic [3:0] starve_q, starve_d;

    assign gnt_i = i_cand & (~d_cand | (starve_q == 4'd15));
    assign gnt_d = d_cand & ~gnt_i;

    always_comb begin
        starve_d = starve_q;
        if (gnt_i)
            starve_d = 4'd0;
        else if (i_cand && starve_q != 4'd15)
            starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_q <= 4'd0;
        else
            starve_q <= starve_d;
    end
`else
    // rr_d_q = 1: D wins the next contested cycle.
    logic rr_d_q, rr_d_d;

    assign gnt_d = d_cand & (~i_cand | rr_d_q);
    assign gnt_i = i_cand & ~gnt_d;

    always_comb begin
        rr_d_d = rr_d_q;
        if (gnt_d)
            rr_d_d = 1'b0;
        else if (gnt_i)
            rr_d_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_d_q <= 1'b1;
        else
            rr_d_q <= rr_d_d;
    end
`endif

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;

    // SRAM drive straight from the granted request in the accept cycle.
    always_comb begin
        ram_csn0 = 1'b1;
        ram_csn1 = 1'b1;
        ram_wen  = 1'b1;
        ram_ben  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt_i) begin
            ram_csn0 = 1'b0;
            ram_csn1 = 1'b0;
            ram_addr = i_req_addr[AW+2:3];
        end else if (gnt_d) begin
            ram_csn0 = d_req_addr[2];
            ram_csn1 = ~d_req_addr[2];
            ram_wen  = ~d_req_wr;
            ram_addr = d_req_addr[AW+2:3];
            ram_din  = {d_req_wdata, d_req_wdata};
            if (d_req_wr)
                ram_ben = d_req_addr[2] ? {d_req_wmask, 4'b0000} : {4'b0000, d_req_wmask};
        end
    end

    // D response data: selected half for reads, zero for write acknowledges.
    assign d_steer = d_wr_q   ? 32'd0 :
                     d_half_q ? ram_dout[63:32] : ram_dout[31:0];

    assign i_rsp_valid = i_hold_vld_q | i_infl_q;
    assign d_rsp_valid = d_hold_vld_q | d_infl_q;
    assign i_rsp_rdata = i_hold_vld_q ? i_hold_q : (i_infl_q ? ram_dout : 64'd0);
    assign d_rsp_rdata = d_hold_vld_q ? d_hold_q : (d_infl_q ? d_steer : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_infl_q     <= 1'b0;
            d_infl_q     <= 1'b0;
            d_half_q     <= 1'b0;
            d_wr_q       <= 1'b0;
            i_hold_vld_q <= 1'b0;
            d_hold_vld_q <= 1'b0;
            i_hold_q     <= '0;
            d_hold_q     <= '0;
        end else begin
            i_infl_q <= gnt_i;
            d_infl_q <= gnt_d;
            if (gnt_d) begin
                d_half_q <= d_req_addr[2];
                d_wr_q   <= d_req_wr;
            end
            // ram_dout is only valid for one cycle, so an unconsumed beat
            // must be parked before the SRAM output moves on.
            if (i_infl_q && !i_rsp_ready) begin
                i_hold_vld_q <= 1'b1;
                i_hold_q     <= ram_dout;
            end else if (i_hold_vld_q && i_rsp_ready) begin
                i_hold_vld_q <= 1'b0;
            end
            if (d_infl_q && !d_rsp_ready) begin
                d_hold_vld_q <= 1'b1;
                d_hold_q     <= d_steer;
            end else if (d_hold_vld_q && d_rsp_ready) begin
                d_hold_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_isram_arb.sv
module tb_isram_arb;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int BW = 8;

    logic            clk;
    logic            rst_n;
    logic            i_req_valid;
    logic            i_req_ready;
    logic [AW+2:0]   i_req_addr;
    logic            i_rsp_valid;
    logic            i_rsp_ready;
    logic [63:0]     i_rsp_rdata;
    logic            d_req_valid;
    logic            d_req_ready;
    logic [AW+2:0]   d_req_addr;
    logic            d_req_wr;
    logic [3:0]      d_req_wmask;
    logic [31:0]     d_req_wdata;
    logic            d_rsp_valid;
    logic            d_rsp_ready;
    logic [31:0]     d_rsp_rdata;
    logic            ram_csn0;
    logic            ram_csn1;
    logic            ram_wen;
    logic [BW-1:0]   ram_ben;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    int tests;
    int fails;

    logic [63:0] mem [0:15];

    isram_arb #(.AW(AW), .DW(DW), .BW(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_req_addr  (i_req_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .i_rsp_rdata (i_rsp_rdata),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_req_addr  (d_req_addr),
        .d_req_wr    (d_req_wr),
        .d_req_wmask (d_req_wmask),
        .d_req_wdata (d_req_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_ready (d_rsp_ready),
        .d_rsp_rdata (d_rsp_rdata),
        .ram_csn0    (ram_csn0),
        .ram_csn1    (ram_csn1),
        .ram_wen     (ram_wen),
        .ram_ben     (ram_ben),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_dout    (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-half SRAM: word k = {C0DE, k, BEEF, k}.
    initial begin
        for (int k = 0; k < 16; k++)
            mem[k] = {16'hC0DE, 16'(k), 16'hBEEF, 16'(k)};
        ram_dout = '0;
        forever begin
            @(posedge clk);
            if (!ram_csn0) begin
                if (!ram_wen) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_ben[b]) mem[ram_addr[3:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
                end else begin
                    ram_dout[31:0] <= mem[ram_addr[3:0]][31:0];
                end
            end
            if (!ram_csn1) begin
                if (!ram_wen) begin
                    for (int b = 4; b < 8; b++)
                        if (ram_ben[b]) mem[ram_addr[3:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
                end else begin
                    ram_dout[63:32] <= mem[ram_addr[3:0]][63:32];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = '0;
        i_rsp_ready = 1'b1;
        d_req_valid = 1'b1;
        d_req_addr  = '0;
        d_req_wr    = 1'b0;
        d_req_wmask = 4'h0;
        d_req_wdata = '0;
        d_rsp_ready = 1'b1;

        // Reset state, with requests pending to show they are not granted.
        repeat (2) @(negedge clk);
        #1;
        check("rst_i_req_ready", i_req_ready, 1'b0);
        check("rst_d_req_ready", d_req_ready, 1'b0);
        check("rst_i_rsp_valid", i_rsp_valid, 1'b0);
        check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("rst_i_rdata", i_rsp_rdata, 64'd0);
        check("rst_d_rdata", d_rsp_rdata, 32'd0);
        check("rst_csn0", ram_csn0, 1'b1);
        check("rst_csn1", ram_csn1, 1'b1);
        check("rst_wen", ram_wen, 1'b1);
        check("rst_ben", ram_ben, 8'h00);
        check("rst_addr", ram_addr, 16'h0);
        check("rst_din", ram_din, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;

        // I-only read of word 8.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr  = 19'h40;
        #1;
        check("t1_i_ready", i_req_ready, 1'b1);
        check("t1_d_ready", d_req_ready, 1'b0);
        check("t1_csn0", ram_csn0, 1'b0);
        check("t1_csn1", ram_csn1, 1'b0);
        check("t1_wen", ram_wen, 1'b1);
        check("t1_addr", ram_addr, 16'd8);
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        check("t1_i_rsp_valid", i_rsp_valid, 1'b1);
        check("t1_i_rdata", i_rsp_rdata, 64'hC0DE0008_BEEF0008);

        // D write high half of word 8, bytes 0..1 of the half.
        @(negedge clk);
        d_req_valid = 1'b1;
        d_req_addr  = 19'h44;
        d_req_wr    = 1'b1;
        d_req_wmask = 4'b0011;
        d_req_wdata = 32'hAABBCCDD;
        #1;
        check("t2_i_rsp_valid_idle", i_rsp_valid, 1'b0);
        check("t2_d_ready", d_req_ready, 1'b1);
        check("t2_csn0", ram_csn0, 1'b1);
        check("t2_csn1", ram_csn1, 1'b0);
        check("t2_wen", ram_wen, 1'b0);
        check("t2_ben", ram_ben, 8'b0011_0000);
        check("t2_addr", ram_addr, 16'd8);
        check("t2_din", ram_din, 64'hAABBCCDD_AABBCCDD);
        // I reads the freshly written word right after the write.
        @(negedge clk);
        d_req_valid = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 19'h40;
        #1;
        check("t2_wr_rsp_valid", d_rsp_valid, 1'b1);
        check("t2_wr_rsp_rdata", d_rsp_rdata, 32'd0);
        check("t2_i_ready", i_req_ready, 1'b1);
        // D read back of the same half.
        @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr  = 19'h44;
        d_req_wr    = 1'b0;
        #1;
        check("t2_i_raw_valid", i_rsp_valid, 1'b1);
        check("t2_i_raw_rdata", i_rsp_rdata, 64'hC0DECCDD_BEEF0008);
        check("t2_d_wr_rsp_gone", d_rsp_valid, 1'b0);
        check("t2_rd_ready", d_req_ready, 1'b1);
        check("t2_rd_wen", ram_wen, 1'b1);
        check("t2_rd_ben", ram_ben, 8'h00);
        check("t2_rd_csn1", ram_csn1, 1'b0);
        check("t2_rd_csn0", ram_csn0, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        check("t2_rd_rsp_valid", d_rsp_valid, 1'b1);
        check("t2_rd_rsp_rdata", d_rsp_rdata, 32'hC0DECCDD);

`ifndef ISRAM_ARB_DPRIO_EN
        // Both ports every cycle after a fresh reset: D,I,D,I,...
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d_req_valid = 1'b1;
            d_req_addr  = 19'h10;
            d_req_wr    = 1'b0;
            i_req_valid = 1'b1;
            i_req_addr  = 19'h08;
            #1;
            check("t3_d_ready", d_req_ready, (c % 2) == 0);
            check("t3_i_ready", i_req_ready, (c % 2) == 1);
            if (c % 2 == 1) begin
                check("t3_d_rsp_valid", d_rsp_valid, 1'b1);
                check("t3_d_rdata", d_rsp_rdata, 32'hBEEF0002);
                check("t3_i_rsp_idle", i_rsp_valid, 1'b0);
            end else if (c > 0) begin
                check("t3_i_rsp_valid", i_rsp_valid, 1'b1);
                check("t3_i_rdata", i_rsp_rdata, 64'hC0DE0001_BEEF0001);
                check("t3_d_rsp_idle", d_rsp_valid, 1'b0);
            end
        end
        @(negedge clk);
        d_req_valid = 1'b0;
        i_req_valid = 1'b0;
        #1;
        check("t3_last_i_rsp", i_rsp_valid, 1'b1);
`endif

        // I response stalled for 3 cycles while D keeps working.
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr  = 19'h18;
        i_rsp_ready = 1'b0;
        #1;
        check("t4_i_ready", i_req_ready, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b1;
        d_req_addr  = 19'h14;
        d_req_wr    = 1'b0;
        #1;
        check("t4_h1_valid", i_rsp_valid, 1'b1);
        check("t4_h1_rdata", i_rsp_rdata, 64'hC0DE0003_BEEF0003);
        check("t4_h1_i_ready", i_req_ready, 1'b0);
        check("t4_h1_d_ready", d_req_ready, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        check("t4_h2_valid", i_rsp_valid, 1'b1);
        check("t4_h2_rdata", i_rsp_rdata, 64'hC0DE0003_BEEF0003);
        check("t4_h2_i_ready", i_req_ready, 1'b0);
        check("t4_h2_d_rsp_valid", d_rsp_valid, 1'b1);
        check("t4_h2_d_rdata", d_rsp_rdata, 32'hC0DE0002);
        @(negedge clk);
        #1;
        check("t4_h3_valid", i_rsp_valid, 1'b1);
        check("t4_h3_rdata", i_rsp_rdata, 64'hC0DE0003_BEEF0003);
        @(negedge clk);
        i_rsp_ready = 1'b1;
        #1;
        check("t4_h4_valid", i_rsp_valid, 1'b1);
        check("t4_h4_rdata", i_rsp_rdata, 64'hC0DE0003_BEEF0003);
        check("t4_h4_i_ready", i_req_ready, 1'b0);
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        check("t4_h5_valid", i_rsp_valid, 1'b0);

        // Reset in the cycle after a D read handshake.
        @(negedge clk);
        d_req_valid = 1'b1;
        d_req_addr  = 19'h10;
        d_req_wr    = 1'b0;
        #1;
        check("t5_d_ready", d_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("t5_rst_d_rdata", d_rsp_rdata, 32'd0);
        check("t5_rst_csn0", ram_csn0, 1'b1);
        check("t5_rst_csn1", ram_csn1, 1'b1);
        check("t5_rst_d_ready", d_req_ready, 1'b0);
        @(negedge clk);
        d_req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("t5_post_d_rsp_valid", d_rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check("t5_post2_d_rsp_valid", d_rsp_valid, 1'b0);
        check("t5_post2_csn0", ram_csn0, 1'b1);

`ifdef ISRAM_ARB_DPRIO_EN
        // D priority: I wins only on its 16th waiting cycle.
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            d_req_valid = 1'b1;
            d_req_addr  = 19'h10;
            d_req_wr    = 1'b0;
            i_req_valid = 1'b1;
            i_req_addr  = 19'h08;
            #1;
            check("t6_i_ready", i_req_ready, k == 16);
            check("t6_d_ready", d_req_ready, k != 16);
        end
        @(negedge clk);
        d_req_valid = 1'b0;
        i_req_valid = 1'b0;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
